// File: rtl/cfg_noc_pkg.sv
// Shared definitions for the DDR configuration network: flit types, header layout,
// injector FSM encoding and a header builder.
package cfg_noc_pkg;

    localparam int unsigned DATAW = 34;

    localparam logic [1:0] FT_HEAD = 2'b10;
    localparam logic [1:0] FT_BODY = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b11;

    localparam int unsigned HDR_Y_MSB   = 31;
    localparam int unsigned HDR_Y_LSB   = 28;
    localparam int unsigned HDR_X_MSB   = 27;
    localparam int unsigned HDR_X_LSB   = 24;
    localparam int unsigned HDR_REQ_BIT = 23;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHead = 2'd1,
        StBody = 2'd2,
        StTail = 2'd3
    } inj_state_e;

    // Header payload; all bits below the cfgreq flag are zero.
    function automatic logic [31:0] make_header(input logic [3:0] y,
                                                input logic [3:0] x,
                                                input logic       creq);
        logic [31:0] hdr;
        hdr                        = '0;
        hdr[HDR_Y_MSB:HDR_Y_LSB]   = y;
        hdr[HDR_X_MSB:HDR_X_LSB]   = x;
        hdr[HDR_REQ_BIT]           = creq;
        return hdr;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester above last_gnt_i,
// wrapping around. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_gnt_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            vld_o
);

    int unsigned w_last;
    int unsigned w_cand;

    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        vld_o  = 1'b0;
        w_last = 32'(last_gnt_i);
        w_cand = 0;
        // Offsets 1..NREQ put last_gnt itself at lowest priority.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = (w_last + k) % NREQ;
            if (!vld_o && req_i[IDXW'(w_cand)]) begin
                vld_o                  = 1'b1;
                gnt_o[IDXW'(w_cand)]   = 1'b1;
                idx_o                  = IDXW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/cfg_inject_arb.sv
// Configuration-packet injector: round-robin among requesters, then serialises
// header, LEN body flits and a tail onto the configuration network.
module cfg_inject_arb #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DATAW = cfg_noc_pkg::DATAW,
    parameter int unsigned LENW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [4*NREQ-1:0]        dst_y_i,
    input  logic [4*NREQ-1:0]        dst_x_i,
    input  logic [NREQ-1:0]          creq_i,
    input  logic [LENW*NREQ-1:0]     len_i,
    input  logic [NREQ-1:0]          dat_vld_i,
    input  logic [(DATAW-2)*NREQ-1:0] dat_i,
    output logic [NREQ-1:0]          dat_rdy_o,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          done_o,
    output logic                     fwd_o,
    output logic [DATAW-1:0]         data_o,
    input  logic                     rdy_i
);
    import cfg_noc_pkg::*;

    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned PW   = DATAW - 2;

    inj_state_e      r_state;
    inj_state_e      w_state_next;

    logic [NREQ-1:0] r_gnt;
    logic [IDXW-1:0] r_gidx;
    logic [IDXW-1:0] r_last_gnt;
    logic [3:0]      r_y;
    logic [3:0]      r_x;
    logic            r_creq;
    logic [LENW-1:0] r_len;
    logic [LENW-1:0] r_cnt;

    logic [NREQ-1:0] w_arb_gnt;
    logic [IDXW-1:0] w_arb_idx;
    logic            w_arb_vld;
    logic            w_body_xfer;
    logic            w_body_last;
    logic [PW-1:0]   w_hdr;

    logic [3:0]      w_y_arr   [NREQ];
    logic [3:0]      w_x_arr   [NREQ];
    logic [LENW-1:0] w_len_arr [NREQ];
    logic [PW-1:0]   w_dat_arr [NREQ];

    always_comb begin
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_y_arr[k]   = dst_y_i[4*k +: 4];
            w_x_arr[k]   = dst_x_i[4*k +: 4];
            w_len_arr[k] = len_i[LENW*k +: LENW];
            w_dat_arr[k] = dat_i[PW*k +: PW];
        end
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .req_i      (req_i),
        .last_gnt_i (r_last_gnt),
        .gnt_o      (w_arb_gnt),
        .idx_o      (w_arb_idx),
        .vld_o      (w_arb_vld)
    );

    assign w_hdr       = PW'(make_header(r_y, r_x, r_creq));
    // Only meaningful in BODY, which is entered only with a non-zero length.
    assign w_body_last = (r_len != '0) && (r_cnt == r_len - LENW'(1));
    assign gnt_o       = r_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_arb_vld) w_state_next = StHead;
            StHead: if (rdy_i) w_state_next = (r_len != '0) ? StBody : StTail;
            StBody: if (w_body_xfer && w_body_last) w_state_next = StTail;
            StTail: if (rdy_i) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        fwd_o       = 1'b0;
        data_o      = '0;
        dat_rdy_o   = '0;
        done_o      = '0;
        w_body_xfer = 1'b0;
        unique case (r_state)
            StHead: begin
                fwd_o  = 1'b1;
                data_o = {FT_HEAD, w_hdr};
            end
            StBody: begin
                fwd_o       = dat_vld_i[r_gidx];
                data_o      = {FT_BODY, w_dat_arr[r_gidx]};
                dat_rdy_o   = rdy_i ? r_gnt : '0;
                w_body_xfer = dat_vld_i[r_gidx] & rdy_i;
            end
            StTail: begin
                fwd_o  = 1'b1;
                data_o = {FT_TAIL, {PW{1'b0}}};
                done_o = rdy_i ? r_gnt : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_last_gnt <= IDXW'(NREQ - 1);
            r_y        <= '0;
            r_x        <= '0;
            r_creq     <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
        end else begin
            // Job fields are captured once at grant and ignored afterwards.
            if (r_state == StIdle && w_arb_vld) begin
                r_gnt  <= w_arb_gnt;
                r_gidx <= w_arb_idx;
                r_y    <= w_y_arr[w_arb_idx];
                r_x    <= w_x_arr[w_arb_idx];
                r_creq <= creq_i[w_arb_idx];
                r_len  <= w_len_arr[w_arb_idx];
                r_cnt  <= '0;
            end
            if (w_body_xfer) begin
                r_cnt <= r_cnt + LENW'(1);
            end
            if (r_state == StTail && rdy_i) begin
                r_last_gnt <= r_gidx;
                r_gnt      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cfg_inject_arb.sv
// Directed bench for cfg_inject_arb: single job, zero length, round-robin order,
// backpressure, source stall and reset in the middle of a body.
module tb_cfg_inject_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned DATAW = 34;
    localparam int unsigned LENW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] dst_y;
    logic [4*NREQ-1:0] dst_x;
    logic [NREQ-1:0]   creq;
    logic [LENW*NREQ-1:0] len;
    logic [NREQ-1:0]   dat_vld;
    logic [32*NREQ-1:0] dat;
    logic [NREQ-1:0]   dat_rdy;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              fwd;
    logic [DATAW-1:0]  data;
    logic              rdy;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [33:0] TAIL = 34'h3_0000_0000;

    cfg_inject_arb #(
        .NREQ  (NREQ),
        .DATAW (DATAW),
        .LENW  (LENW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .dst_y_i   (dst_y),
        .dst_x_i   (dst_x),
        .creq_i    (creq),
        .len_i     (len),
        .dat_vld_i (dat_vld),
        .dat_i     (dat),
        .dat_rdy_o (dat_rdy),
        .gnt_o     (gnt),
        .done_o    (done),
        .fwd_o     (fwd),
        .data_o    (data),
        .rdy_i     (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_job(input int k, input logic [3:0] y, input logic [3:0] x,
                           input logic c, input logic [7:0] l);
        dst_y[4*k +: 4] = y;
        dst_x[4*k +: 4] = x;
        creq[k]         = c;
        len[8*k +: 8]   = l;
    endtask

    function automatic logic [33:0] hdr(input logic [3:0] y, input logic [3:0] x,
                                        input logic c);
        return {2'b10, y, x, c, 23'd0};
    endfunction

    function automatic logic [33:0] body(input logic [31:0] w);
        return {2'b01, w};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ord_tbl[5] = '{0, 1, 2, 3, 0};
        int o;
        rst = 1'b1; req = '0; dst_y = '0; dst_x = '0; creq = '0; len = '0;
        dat_vld = '0; dat = '0; rdy = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_fwd", 64'(fwd), 64'd0);
        check("rst_data", 64'(data), 64'd0);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_dat_rdy", 64'(dat_rdy), 64'd0);
        check("rst_done", 64'(done), 64'd0);

        // Single job, requester 0, len 3
        @(negedge clk); rst = 1'b0;
        set_job(0, 4'd1, 4'd1, 1'b1, 8'd3);
        req = 4'b0001; dat_vld = 4'b0001; dat[31:0] = 32'hA; #1;
        check("t1_idle_fwd", 64'(fwd), 64'd0);
        @(negedge clk); #1;
        check("t1_hdr", 64'(data), 64'h2_1180_0000);
        check("t1_hdr_fwd", 64'(fwd), 64'd1);
        check("t1_gnt", 64'(gnt), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dat[31:0] = 32'hA + 32'(i); #1;
            check("t1_body", 64'(data), 64'(body(32'hA + 32'(i))));
            check("t1_dat_rdy", 64'(dat_rdy), 64'd1);
            check("t1_no_done", 64'(done), 64'd0);
        end
        @(negedge clk); #1;
        check("t1_tail", 64'(data), 64'(TAIL));
        check("t1_done", 64'(done), 64'd1);
        req = '0; dat_vld = '0;
        @(negedge clk); #1;
        check("t1_after_fwd", 64'(fwd), 64'd0);
        check("t1_after_gnt", 64'(gnt), 64'd0);
        check("t1_after_done", 64'(done), 64'd0);

        // Zero length, requester 1
        set_job(1, 4'd2, 4'd3, 1'b0, 8'd0);
        req = 4'b0010; #1;
        check("t2_idle_fwd", 64'(fwd), 64'd0);
        @(negedge clk); #1;
        check("t2_hdr", 64'(data), 64'h2_2300_0000);
        check("t2_hdr_dat_rdy", 64'(dat_rdy), 64'd0);
        @(negedge clk); #1;
        check("t2_tail", 64'(data), 64'(TAIL));
        check("t2_tail_dat_rdy", 64'(dat_rdy), 64'd0);
        check("t2_done", 64'(done), 64'b0010);
        req = '0;
        @(negedge clk); #1;
        check("t2_after_fwd", 64'(fwd), 64'd0);

        // Round-robin from a fresh pointer: order 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_job(k, 4'(k + 1), 4'(k + 2), k[0], 8'd1);
            dat[32*k +: 32] = 32'hB0 + 32'(k);
        end
        dat_vld = 4'b1111; req = 4'b1111; #1;
        check("t3_idle_fwd", 64'(fwd), 64'd0);
        for (int p = 0; p < 5; p++) begin
            o = ord_tbl[p];
            @(negedge clk); #1;
            check("t3_gnt", 64'(gnt), 64'(4'b0001 << o));
            check("t3_hdr", 64'(data), 64'(hdr(4'(o + 1), 4'(o + 2), o[0])));
            @(negedge clk); #1;
            check("t3_body", 64'(data), 64'(body(32'hB0 + 32'(o))));
            check("t3_dat_rdy", 64'(dat_rdy), 64'(4'b0001 << o));
            @(negedge clk); #1;
            check("t3_done", 64'(done), 64'(4'b0001 << o));
            @(negedge clk); #1;
            check("t3_idle_gnt", 64'(gnt), 64'd0);
            check("t3_idle_fwd", 64'(fwd), 64'd0);
        end
        req = '0; dat_vld = '0;

        // Backpressure on header, body and tail; requester 1, len 2
        @(negedge clk);
        set_job(1, 4'd4, 4'd5, 1'b1, 8'd2);
        req = 4'b0010; dat_vld = 4'b0010; dat[63:32] = 32'hD1; rdy = 1'b1; #1;
        check("t4_idle_fwd", 64'(fwd), 64'd0);
        @(negedge clk); rdy = 1'b0; #1;
        check("t4_hdr_stall", 64'(data), 64'h2_4580_0000);
        check("t4_hdr_fwd", 64'(fwd), 64'd1);
        @(negedge clk); rdy = 1'b0; #1;
        check("t4_hdr_hold", 64'(data), 64'h2_4580_0000);
        @(negedge clk); rdy = 1'b1; #1;
        check("t4_hdr_go", 64'(data), 64'h2_4580_0000);
        @(negedge clk); rdy = 1'b0; #1;
        check("t4_b0_stall", 64'(data), 64'(body(32'hD1)));
        check("t4_b0_rdy_lo", 64'(dat_rdy), 64'd0);
        @(negedge clk); rdy = 1'b1; #1;
        check("t4_b0_go", 64'(data), 64'(body(32'hD1)));
        check("t4_b0_rdy_hi", 64'(dat_rdy), 64'b0010);
        @(negedge clk); dat[63:32] = 32'hD2; rdy = 1'b0; #1;
        check("t4_b1_stall", 64'(data), 64'(body(32'hD2)));
        check("t4_b1_no_done", 64'(done), 64'd0);
        @(negedge clk); rdy = 1'b1; #1;
        check("t4_b1_go", 64'(data), 64'(body(32'hD2)));
        @(negedge clk); rdy = 1'b0; #1;
        check("t4_tail_stall", 64'(data), 64'(TAIL));
        check("t4_tail_no_done", 64'(done), 64'd0);
        @(negedge clk); rdy = 1'b1; #1;
        check("t4_tail_go", 64'(data), 64'(TAIL));
        check("t4_done", 64'(done), 64'b0010);
        req = '0; dat_vld = '0;
        @(negedge clk); #1;
        check("t4_after_fwd", 64'(fwd), 64'd0);
        check("t4_after_done", 64'(done), 64'd0);

        // Source stall for 5 cycles mid-body; requester 2, len 3
        set_job(2, 4'd6, 4'd7, 1'b0, 8'd3);
        req = 4'b0100; dat_vld = 4'b0100; dat[95:64] = 32'hE0; #1;
        check("t5_idle_fwd", 64'(fwd), 64'd0);
        @(negedge clk); #1;
        check("t5_hdr", 64'(data), 64'h2_6700_0000);
        @(negedge clk); #1;
        check("t5_b0", 64'(data), 64'(body(32'hE0)));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); dat_vld = '0; dat[95:64] = 32'hE1; #1;
            check("t5_stall_fwd", 64'(fwd), 64'd0);
        end
        @(negedge clk); dat_vld = 4'b0100; #1;
        check("t5_b1", 64'(data), 64'(body(32'hE1)));
        check("t5_b1_fwd", 64'(fwd), 64'd1);
        @(negedge clk); dat[95:64] = 32'hE2; #1;
        check("t5_b2", 64'(data), 64'(body(32'hE2)));
        @(negedge clk); #1;
        check("t5_tail", 64'(data), 64'(TAIL));
        check("t5_done", 64'(done), 64'b0100);
        req = '0; dat_vld = '0;
        @(negedge clk); #1;
        check("t5_after_fwd", 64'(fwd), 64'd0);

        // Reset after the 2nd body flit; requester 3, len 4
        set_job(3, 4'd8, 4'd9, 1'b1, 8'd4);
        req = 4'b1000; dat_vld = 4'b1000; dat[127:96] = 32'hF0; #1;
        check("t6_idle_fwd", 64'(fwd), 64'd0);
        @(negedge clk); #1;
        check("t6_hdr", 64'(data), 64'h2_8980_0000);
        @(negedge clk); #1;
        check("t6_b0", 64'(data), 64'(body(32'hF0)));
        @(negedge clk); dat[127:96] = 32'hF1; #1;
        check("t6_b1", 64'(data), 64'(body(32'hF1)));
        @(negedge clk); rst = 1'b1; dat[127:96] = 32'hF2;
        set_job(0, 4'd1, 4'd1, 1'b1, 8'd0);
        req = 4'b1001; #1;
        @(negedge clk); rst = 1'b0; #1;
        check("t6_rst_fwd", 64'(fwd), 64'd0);
        check("t6_rst_data", 64'(data), 64'd0);
        check("t6_rst_gnt", 64'(gnt), 64'd0);
        check("t6_rst_dat_rdy", 64'(dat_rdy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        @(negedge clk); #1;
        check("t6_regrant", 64'(gnt), 64'b0001);
        check("t6_regrant_hdr", 64'(data), 64'h2_1180_0000);
        @(negedge clk); #1;
        check("t6_regrant_done", 64'(done), 64'b0001);
        req = '0; dat_vld = '0;
        @(negedge clk); #1;
        check("t6_after_fwd", 64'(fwd), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cfg_inject_arb.md
# cfg_inject_arb

Configuration-packet injector and arbiter for the DDR configuration network. It shares one injection port among NREQ configuration requesters using round-robin arbitration. For each granted job it serialises a header flit, LEN body flits and a tail flit onto the network. Its output stream is the one decoded by the tile configuration ports: 2-bit flit type plus 32-bit payload, addressed by LOCAL_Y/LOCAL_X.

## Interface
Parameters:
- NREQ, 4: number of requesters, at least 2.
- DATAW, 34: flit width. Bits [DATAW-1:DATAW-2] are the flit type; bits [DATAW-3:0] are the payload.
- LENW, 8: width of the body-flit count.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_i  in  NREQ  job request per requester. The requester holds it until its done_o pulse.
- dst_y_i  in  4*NREQ  target Y per requester, flattened; requester k uses bits [4k+3:4k].
- dst_x_i  in  4*NREQ  target X per requester, same packing.
- creq_i  in  NREQ  cfgreq bit per requester, placed in header bit 23.
- len_i  in  LENW*NREQ  body-flit count per requester, range 0..2^LENW-1.
- dat_vld_i  in  NREQ  body-word valid per requester.
- dat_i  in  (DATAW-2)*NREQ  body word per requester.
- dat_rdy_o  out  NREQ  body-word accept per requester. Asserted only for the granted requester.
- gnt_o  out  NREQ  one-hot grant, held from the HEAD state through the TAIL state.
- done_o  out  NREQ  one-cycle pulse when the granted requester's tail flit is accepted.
- fwd_o  out  1  flit valid toward the network.
- data_o  out  DATAW  flit toward the network.
- rdy_i  in  1  network ready. A flit transfers when fwd_o=1 and rdy_i=1.

## Operation
- Flit formats:
  - Header: type 2'b10; [31:28] = Y; [27:24] = X; [23] = creq; [22:0] = 0.
  - Body: type 2'b01; [31:0] = word.
  - Tail: type 2'b11; payload = 0.
- FSM states: IDLE, HEAD, BODY, TAIL. Reset puts the FSM in IDLE.
- IDLE:
  - If any req_i bit is set, the round-robin picks the first set bit searching upward from last_gnt+1, with wrap-around.
  - On that edge, register gnt, Y, X, creq and len for the winner, and go to HEAD.
  - In IDLE, fwd_o=0.
- HEAD:
  - fwd_o=1 and data_o = header.
  - On transfer, go to BODY if len≠0, otherwise go to TAIL.
- BODY:
  - fwd_o = dat_vld_i[g] and data_o = {2'b01, dat_i[g]}.
  - dat_rdy_o[g] = rdy_i.
  - Each transfer increments cnt, which is LENW bits and cleared on grant.
  - The transfer with cnt == len-1 moves the FSM to TAIL.
- TAIL:
  - fwd_o=1 and data_o = tail.
  - On transfer: done_o[g]=1 in the same cycle, last_gnt ← g, and go to IDLE.
- Arithmetic: the len-1 compare is done in LENW bits, and is only evaluated when len≠0.
- Field latching: job fields are latched only at grant. Changes to len_i, dst_*_i or creq_i during a packet are ignored.
- Dropped requests: if req_i is deasserted mid-packet, the packet still completes. Body stalls until dat_vld_i returns.
- Backpressure: while fwd_o=1 and rdy_i=0, data_o is unchanged in HEAD and TAIL. In BODY, the requester must hold dat_i stable while valid and not ready.

## Timing
- Reset values: fwd_o=0, data_o=0, gnt_o=0, dat_rdy_o=0, done_o=0, last_gnt=NREQ-1 (so requester 0 wins first), cnt=0.
- Reset mid-packet aborts the packet with no tail and no done. The network-side port recovers on its next header.
- Header latency: the header appears on fwd_o one cycle after req_i is seen in IDLE.
- Back-to-back packets: at least one IDLE cycle separates consecutive packets.
- Packet length: a packet with no stalls takes LEN+2 transfer cycles.
- Body path: fwd_o, data_o and dat_rdy_o are combinational from registered state plus dat_vld_i, dat_i and rdy_i. There is no internal data buffering.
- done_o and the rdy_i-qualified tail transfer occur in the same cycle.
- A new request arriving during the TAIL cycle is arbitrated in the following IDLE cycle.

## Structure
- Shared package cfg_noc_pkg holds:
  - Flit type constants: FT_HEAD=2'b10, FT_BODY=2'b01, FT_TAIL=2'b11.
  - DATAW.
  - Header field bit positions: Y [31:28], X [27:24], REQ [23].
  - FSM state encoding.
- One sub-module, rr_arbiter (NREQ):
  - Inputs: req vector and last_gnt.
  - Outputs: one-hot grant and encoded index. Combinational.
  - The pointer register stays in cfg_inject_arb.

## Test plan
- Single job: requester 0 with Y=1, X=1, creq=1, len=3, words A,B,C, rdy_i=1. Required: flits 0x2_1180_0000, then 0x1_A, 0x1_B, 0x1_C, then 0x3_0000_0000 on consecutive cycles; done_o[0] pulses with the tail.
- Zero length: len=0. Required: header then tail, no dat_rdy_o assertion, done_o pulse.
- Round-robin: all four requesters request continuously with len=1. Required grant order 0, 1, 2, 3, 0, and every done_o pulse precedes the next grant.
- Backpressure: rdy_i toggling 1-0-1 during header, body and tail. Required: data_o is stable while stalled, no flit is duplicated or lost, and the cnt sequence is intact.
- Source stall: dat_vld_i low for 5 cycles in the middle of the body. Required: fwd_o=0 for those cycles, the packet resumes, and the body count is still LEN.
- Reset mid-body: rst=1 for one cycle after the 2nd body flit. Required: next cycle all outputs are 0 and the FSM is in IDLE. The next grant goes to requester 0.
